word_scroller: RTL and testbench

Message source for the letter displays: accepts an ASCII string over a valid/ready byte stream, stores it, and scrolls it right-to-left across a row of `DIGITS` display positions. It outputs one 8-bit ASCII code per digit. Each code feeds the team's ASCII-to-seven-segment letter decoder, one decoder per digit. It is the producer end of the ASCII character interface those decoders consume.

---
 rtl/word_scroller_if.sv | 28 ++
 rtl/word_scroller.sv | 121 ++++++++++++
 tb/tb_word_scroller.sv | 265 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/word_scroller_if.sv
// ============================================================================
// word_scroller_if : valid/ready ASCII character stream into the scroller
// Rev 1.0
// ============================================================================
`default_nettype none

interface word_scroller_if;
  logic [7:0] char_in;
  logic       char_valid;
  logic       char_last;
  logic       char_ready;

  modport master (
    output char_in,
    output char_valid,
    output char_last,
    input  char_ready
  );

  modport slave (
    input  char_in,
    input  char_valid,
    input  char_last,
    output char_ready
  );
endinterface

`default_nettype wire

// File: rtl/word_scroller.sv
// ============================================================================
// word_scroller : buffers an ASCII message and scrolls it right-to-left
// across DIGITS display positions, one character per TICKDIV cycles.
// Rev 1.0
// ============================================================================
`default_nettype none

module word_scroller #(
  parameter int DIGITS  = 4,
  parameter int MAXLEN  = 16,
  parameter int TICKDIV = 25_000_000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clear,
  word_scroller_if.slave        chr,
  input  logic                  pause,
  output logic [8*DIGITS-1:0]   digit_chars,
  output logic                  scrolling,
  output logic                  step_pulse
);

  localparam int LW = $clog2(MAXLEN + DIGITS + 1);
  localparam int IW = LW + 1;
  localparam int TW = $clog2(TICKDIV);
  localparam int AW = (MAXLEN > 1) ? $clog2(MAXLEN) : 1;

  localparam logic [LW-1:0] C_MAXLEN    = LW'(MAXLEN);
  localparam logic [LW-1:0] C_DIGITS    = LW'(DIGITS);
  localparam logic [TW-1:0] C_TICK_LAST = TW'(TICKDIV - 1);
  localparam logic [7:0]    C_BLANK     = 8'h20;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD   = 2'd1,
    SCROLL = 2'd2
  } state_t;

  state_t          state;
  logic [LW-1:0]   len;
  logic [LW-1:0]   offset;
  logic [TW-1:0]   tick_cnt;
  logic [7:0]      msg_buf [MAXLEN];

  logic            accept;
  logic [LW-1:0]   len_next;
  logic [LW-1:0]   period;
  logic            commit;

  assign chr.char_ready = (state != SCROLL);
  assign scrolling      = (state == SCROLL);
  assign accept         = chr.char_valid && (state != SCROLL);
  assign len_next       = len + LW'(1);
  assign period         = len + C_DIGITS;
  // A full buffer commits even without the last-character marker.
  assign commit         = chr.char_last || (len_next == C_MAXLEN);

  // Message storage has no reset; only entries below len are ever shown.
  always_ff @(posedge clk) begin
    if (accept) begin
      msg_buf[len[AW-1:0]] <= chr.char_in;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      state      <= IDLE;
      len        <= '0;
      offset     <= '0;
      tick_cnt   <= '0;
      step_pulse <= 1'b0;
    end else begin
      step_pulse <= 1'b0;
      case (state)
        IDLE, LOAD: begin
          if (accept) begin
            len <= len_next;
            if (commit) begin
              state    <= SCROLL;
              offset   <= '0;
              tick_cnt <= '0;
            end else begin
              state    <= LOAD;
            end
          end
        end
        SCROLL: begin
          if (!pause) begin
            if (tick_cnt == C_TICK_LAST) begin
              tick_cnt   <= '0;
              step_pulse <= 1'b1;
              offset     <= (offset == period - LW'(1)) ? '0 : offset + LW'(1);
            end else begin
              tick_cnt   <= tick_cnt + TW'(1);
            end
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // Window index into the virtual string: leading DIGITS blanks, then the
  // message. offset+k stays below 2*period, so one conditional subtract wraps it.
  for (genvar k = 0; k < DIGITS; k++) begin : g_digit
    logic [IW-1:0] raw;
    logic [IW-1:0] idx;
    logic [AW-1:0] pos;

    assign raw = IW'(offset) + IW'(k);
    assign idx = (raw >= IW'(period)) ? raw - IW'(period) : raw;
    assign pos = AW'(idx - IW'(DIGITS));
    assign digit_chars[8*(DIGITS-k)-1 -: 8] =
      (scrolling && (idx >= IW'(DIGITS))) ? msg_buf[pos] : C_BLANK;
  end

endmodule

`default_nettype wire

// File: tb/tb_word_scroller.sv
// ============================================================================
// tb_word_scroller : directed vectors and scroll sequences for word_scroller
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_word_scroller;

  localparam int DIGITS  = 4;
  localparam int MAXLEN  = 8;
  localparam int TICKDIV = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        clear;
  logic        pause;
  logic [31:0] digit_chars;
  logic        scrolling;
  logic        step_pulse;

  int checks = 0;
  int errors = 0;

  word_scroller_if cif ();

  word_scroller #(
    .DIGITS (DIGITS),
    .MAXLEN (MAXLEN),
    .TICKDIV(TICKDIV)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .clear      (clear),
    .chr        (cif),
    .pause      (pause),
    .digit_chars(digit_chars),
    .scrolling  (scrolling),
    .step_pulse (step_pulse)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        valid;
    logic        last;
    logic [7:0]  ch;
    logic        rdy;
    logic        scr;
    logic        stp;
    logic [31:0] dig;
  } vec_t;

  vec_t tbl [13];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%b expected=%b @%0t", name, act, exp, $time);
    end
  endtask

  task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h @%0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_int(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d @%0t", name, act, exp, $time);
    end
  endtask

  // Expected window for a message at a given offset.
  function automatic logic [31:0] win(input string msg, input int off);
    int          p;
    int          i;
    logic [31:0] r;
    p = msg.len() + DIGITS;
    r = '0;
    for (int k = 0; k < DIGITS; k++) begin
      i = (off + k) % p;
      r[8*(DIGITS-k)-1 -: 8] = (i < DIGITS) ? 8'h20 : msg[i-DIGITS];
    end
    return r;
  endfunction

  task automatic send(input logic [7:0] ch, input logic last);
    cif.char_valid = 1'b1;
    cif.char_in    = ch;
    cif.char_last  = last;
    tick();
    cif.char_valid = 1'b0;
    cif.char_last  = 1'b0;
  endtask

  task automatic idle_checks(input string name);
    chk1 ({name, "_ready"}, cif.char_ready, 1'b1);
    chk1 ({name, "_scroll"}, scrolling, 1'b0);
    chk1 ({name, "_step"}, step_pulse, 1'b0);
    chk32({name, "_digits"}, digit_chars, 32'h20202020);
  endtask

  task automatic do_clear();
    clear = 1'b1;
    tick();
    clear = 1'b0;
    idle_checks("clear");
  endtask

  // Called right after a step edge numbered n0-1 (or the entry edge for n0=1).
  task automatic check_scroll(input string msg, input int n0, input int n1);
    int p;
    p = msg.len() + DIGITS;
    for (int n = n0; n <= n1; n++) begin
      for (int c = 0; c < TICKDIV - 1; c++) begin
        tick();
        chk1 ("hold_step", step_pulse, 1'b0);
        chk32("hold_digits", digit_chars, win(msg, (n - 1) % p));
      end
      tick();
      chk1 ("step_pulse", step_pulse, 1'b1);
      chk32("step_digits", digit_chars, win(msg, n % p));
      chk1 ("step_ready", cif.char_ready, 1'b0);
    end
  endtask

  initial begin
    int cnt;

    rst = 1'b1; clear = 1'b0; pause = 1'b0;
    cif.char_valid = 1'b0; cif.char_last = 1'b0; cif.char_in = 8'h00;
    tick();
    tick();
    rst = 1'b0;
    idle_checks("reset");

    // HELLO: load phase and first two steps
    tbl[0]  = '{1'b1, 1'b0, 8'h48, 1'b1, 1'b0, 1'b0, "    "};
    tbl[1]  = '{1'b1, 1'b0, 8'h45, 1'b1, 1'b0, 1'b0, "    "};
    tbl[2]  = '{1'b1, 1'b0, 8'h4C, 1'b1, 1'b0, 1'b0, "    "};
    tbl[3]  = '{1'b1, 1'b0, 8'h4C, 1'b1, 1'b0, 1'b0, "    "};
    tbl[4]  = '{1'b1, 1'b1, 8'h4F, 1'b0, 1'b1, 1'b0, "    "};
    tbl[5]  = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, "    "};
    tbl[6]  = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, "    "};
    tbl[7]  = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, "    "};
    tbl[8]  = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1, "   H"};
    tbl[9]  = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, "   H"};
    tbl[10] = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, "   H"};
    tbl[11] = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, "   H"};
    tbl[12] = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1, "  HE"};

    for (int i = 0; i < 13; i++) begin
      cif.char_valid = tbl[i].valid;
      cif.char_last  = tbl[i].last;
      cif.char_in    = tbl[i].ch;
      tick();
      chk1 ($sformatf("vec%0d_ready", i), cif.char_ready, tbl[i].rdy);
      chk1 ($sformatf("vec%0d_scroll", i), scrolling, tbl[i].scr);
      chk1 ($sformatf("vec%0d_step", i), step_pulse, tbl[i].stp);
      chk32($sformatf("vec%0d_digits", i), digit_chars, tbl[i].dig);
    end
    cif.char_valid = 1'b0;
    cif.char_last  = 1'b0;

    // Remaining HELLO steps up to the wrap at step 9 (36 cycles after entry)
    check_scroll("HELLO", 3, 9);
    chk32("hello_wrap_blank", digit_chars, 32'h20202020);

    // Reset mid-scroll
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    idle_checks("rst_mid");

    // Backpressure: gaps between characters
    send("A", 1'b0);
    for (int g = 0; g < 3; g++) begin
      tick();
      chk1("gap_ready", cif.char_ready, 1'b1);
      chk1("gap_scroll", scrolling, 1'b0);
    end
    send("B", 1'b0);
    tick();
    tick();
    send("C", 1'b1);
    chk1("bp_scroll", scrolling, 1'b1);
    check_scroll("ABC", 1, 7);

    // Full buffer auto-commit; a held 9th character must not be taken
    do_clear();
    for (int i = 0; i < MAXLEN; i++) begin
      chk1("full_ready_before", cif.char_ready, 1'b1);
      send(8'h41 + 8'(i), 1'b0);
    end
    chk1("full_commit", scrolling, 1'b1);
    chk1("full_ready_drop", cif.char_ready, 1'b0);
    cif.char_valid = 1'b1;
    cif.char_in    = "Z";
    cif.char_last  = 1'b1;
    check_scroll("ABCDEFGH", 1, 12);
    cif.char_valid = 1'b0;
    cif.char_last  = 1'b0;

    // Single character, direct IDLE to SCROLL
    do_clear();
    send("A", 1'b1);
    chk1("single_scroll", scrolling, 1'b1);
    chk32("single_digits0", digit_chars, "    ");
    check_scroll("A", 1, 5);
    chk32("single_wrap", digit_chars, "    ");

    // Pause for 10 cycles mid-count
    do_clear();
    send("A", 1'b0);
    send("B", 1'b1);
    tick();
    tick();
    pause = 1'b1;
    for (int c = 0; c < 10; c++) begin
      tick();
      chk1("pause_step", step_pulse, 1'b0);
    end
    pause = 1'b0;
    cnt = 12;
    while (!step_pulse && cnt < 40) begin
      tick();
      cnt++;
    end
    chk_int("pause_step_delay", cnt, TICKDIV + 10);
    chk32("pause_digits", digit_chars, "   A");

    // Clear on the edge that would otherwise step
    do_clear();
    send("Q", 1'b1);
    tick();
    tick();
    tick();
    clear = 1'b1;
    tick();
    clear = 1'b0;
    idle_checks("clear_on_step");
    send("Q", 1'b1);
    chk32("clear_restart", digit_chars, "    ");
    check_scroll("Q", 1, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
